// File: rtl/memory_port_arbiter_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
// Holds the FSM state and bus-owner encodings plus the owner selection helper.
package memory_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_FETCH,
    OWNER_DATA
  } bus_owner_e;

  localparam int TIMEOUT_CYCLES_DEFAULT = 64;
  localparam int ADDR_WIDTH_DEFAULT     = 32;

  // Under contention data wins unless it owned the previous transaction.
  function automatic bus_owner_e pick_owner(input logic       fetch_req,
                                            input logic       data_req,
                                            input bus_owner_e last_owner);
    if (data_req && fetch_req) begin
      return (last_owner == OWNER_DATA) ? OWNER_FETCH : OWNER_DATA;
    end
    if (data_req)  return OWNER_DATA;
    if (fetch_req) return OWNER_FETCH;
    return OWNER_NONE;
  endfunction

endpackage

// File: rtl/memory_port_arbiter_if.sv
// Requester and memory-side signals of the unified memory port arbiter.
// The arbiter uses the slave modport; the surrounding pipeline/memory model uses master.
interface memory_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  fetchReq;
  logic [ADDR_WIDTH-1:0] fetchAddr;
  logic                  fetchKill;
  logic [31:0]           fetchData;
  logic                  fetchDataValid;
  logic                  fetchError;

  logic                  dataReadReq;
  logic                  dataWriteReq;
  logic [ADDR_WIDTH-1:0] dataAddr;
  logic [31:0]           dataWdata;
  logic [3:0]            dataByteEnable;
  logic [31:0]           loadData;
  logic                  loadDataValid;
  logic                  storeComplete;
  logic                  dataError;

  logic                  memReq;
  logic                  memWrite;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [31:0]           memWdata;
  logic [3:0]            memByteEnable;
  logic                  memReady;
  logic                  memRespValid;
  logic [31:0]           memRdata;

  logic                  busy;

  modport slave (
    input  fetchReq, fetchAddr, fetchKill,
    input  dataReadReq, dataWriteReq, dataAddr, dataWdata, dataByteEnable,
    input  memReady, memRespValid, memRdata,
    output fetchData, fetchDataValid, fetchError,
    output loadData, loadDataValid, storeComplete, dataError,
    output memReq, memWrite, memAddr, memWdata, memByteEnable,
    output busy
  );

  modport master (
    output fetchReq, fetchAddr, fetchKill,
    output dataReadReq, dataWriteReq, dataAddr, dataWdata, dataByteEnable,
    output memReady, memRespValid, memRdata,
    input  fetchData, fetchDataValid, fetchError,
    input  loadData, loadDataValid, storeComplete, dataError,
    input  memReq, memWrite, memAddr, memWdata, memByteEnable,
    input  busy
  );

endinterface

// File: rtl/memory_port_arbiter_watchdog.sv
// Saturating cycle counter bounding how long a transaction may sit in WAIT.
// expired flags the last allowed WAIT cycle.
module memory_port_arbiter_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int                WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [WIDTH-1:0]  LAST  = WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// one transaction outstanding, response returned to the owning requester.
//
// state    | meaning
// ARB_IDLE | sample requests, pick owner, latch transaction fields
// ARB_REQ  | memReq held with stable fields until memReady
// ARB_WAIT | waiting for memRespValid, watchdog running
// ARB_RESP | one-cycle completion pulse to the owner, requests ignored
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  memory_port_arbiter_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  arb_state_e            state_q, state_d;
  bus_owner_e            owner_q, owner_d, grant;
  logic                  killed_q, killed_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [31:0]           fetch_data_q, fetch_data_d;
  logic [31:0]           load_data_q, load_data_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic                  fetch_error_q, fetch_error_d;
  logic                  load_valid_q, load_valid_d;
  logic                  store_complete_q, store_complete_d;
  logic                  data_error_q, data_error_d;
  logic                  busy_q, busy_d;
  logic                  wd_clear, wd_enable, wd_expired, timed_out;

  memory_port_arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= ARB_IDLE;
      owner_q          <= OWNER_NONE;
      killed_q         <= 1'b0;
      mem_req_q        <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_be_q         <= '0;
      fetch_data_q     <= '0;
      load_data_q      <= '0;
      fetch_valid_q    <= 1'b0;
      fetch_error_q    <= 1'b0;
      load_valid_q     <= 1'b0;
      store_complete_q <= 1'b0;
      data_error_q     <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      killed_q         <= killed_d;
      mem_req_q        <= mem_req_d;
      mem_write_q      <= mem_write_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_be_q         <= mem_be_d;
      fetch_data_q     <= fetch_data_d;
      load_data_q      <= load_data_d;
      fetch_valid_q    <= fetch_valid_d;
      fetch_error_q    <= fetch_error_d;
      load_valid_q     <= load_valid_d;
      store_complete_q <= store_complete_d;
      data_error_q     <= data_error_d;
      busy_q           <= busy_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    killed_d         = killed_q;
    mem_req_d        = mem_req_q;
    mem_write_d      = mem_write_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    mem_be_d         = mem_be_q;
    fetch_data_d     = fetch_data_q;
    load_data_d      = load_data_q;
    fetch_valid_d    = 1'b0;
    fetch_error_d    = 1'b0;
    load_valid_d     = 1'b0;
    store_complete_d = 1'b0;
    data_error_d     = 1'b0;
    wd_clear         = 1'b0;
    wd_enable        = 1'b0;
    timed_out        = 1'b0;
    grant            = pick_owner(bus.fetchReq, bus.dataReadReq | bus.dataWriteReq, owner_q);

    // owner_q doubles as lastOwner once the FSM is back in IDLE
    if ((state_q != ARB_IDLE) && (owner_q == OWNER_FETCH) && bus.fetchKill) begin
      killed_d = 1'b1;
    end

    unique case (state_q)
      ARB_IDLE: begin
        killed_d = 1'b0;
        if (grant != OWNER_NONE) begin
          state_d   = ARB_REQ;
          owner_d   = grant;
          mem_req_d = 1'b1;
          if (grant == OWNER_DATA) begin
            mem_write_d = bus.dataWriteReq;
            mem_addr_d  = bus.dataAddr & WORD_MASK;
            mem_wdata_d = bus.dataWdata;
            mem_be_d    = bus.dataWriteReq ? bus.dataByteEnable : 4'b1111;
          end else begin
            mem_write_d = 1'b0;
            mem_addr_d  = bus.fetchAddr & WORD_MASK;
            mem_wdata_d = '0;
            mem_be_d    = 4'b1111;
          end
        end
      end
      ARB_REQ: begin
        if (bus.memReady) begin
          state_d   = ARB_WAIT;
          mem_req_d = 1'b0;
          wd_clear  = 1'b1;
        end
      end
      ARB_WAIT: begin
        wd_enable = 1'b1;
        if (bus.memRespValid || wd_expired) begin
          state_d   = ARB_RESP;
          timed_out = !bus.memRespValid;
          if (owner_q == OWNER_FETCH) begin
            if (!timed_out) fetch_data_d = bus.memRdata;
            fetch_valid_d = !timed_out && !killed_d;
            fetch_error_d = timed_out && !killed_d;
          end else begin
            if (!timed_out && !mem_write_q) load_data_d = bus.memRdata;
            load_valid_d     = !mem_write_q;
            store_complete_d = mem_write_q;
            data_error_d     = timed_out;
          end
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  assign bus.memReq         = mem_req_q;
  assign bus.memWrite       = mem_write_q;
  assign bus.memAddr        = mem_addr_q;
  assign bus.memWdata       = mem_wdata_q;
  assign bus.memByteEnable  = mem_be_q;
  assign bus.fetchData      = fetch_data_q;
  // A kill arriving in the RESP cycle itself still has to swallow the pulse.
  assign bus.fetchDataValid = fetch_valid_q & ~bus.fetchKill;
  assign bus.fetchError     = fetch_error_q & ~bus.fetchKill;
  assign bus.loadData       = load_data_q;
  assign bus.loadDataValid  = load_valid_q;
  assign bus.storeComplete  = store_complete_q;
  assign bus.dataError      = data_error_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: expected completions are queued when a
// request is issued and matched against every completion pulse the DUT produces.
module tb_memory_port_arbiter;

  localparam logic [4:0] P_FV = 5'b10000;
  localparam logic [4:0] P_LV = 5'b00100;
  localparam logic [4:0] P_SC = 5'b00010;
  localparam logic [4:0] P_DE = 5'b00001;

  typedef struct {
    string      tag;
    logic [4:0] pulses;
    logic [31:0] data;
    bit         check_data;
  } exp_t;

  logic clock;
  logic reset;
  logic mem_auto;
  logic [31:0] rdata_manual;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  memory_port_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  memory_port_arbiter #(
    .TIMEOUT_CYCLES(8),
    .ADDR_WIDTH(32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model data: address-derived in auto mode so every transaction is distinguishable.
  always_comb bus.memRdata = mem_auto ? (bus.memAddr ^ 32'hC0DE_0000) : rdata_manual;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [11:0] ctrl_vec();
    return {bus.memReq, bus.memWrite, bus.memByteEnable, bus.fetchDataValid, bus.fetchError,
            bus.loadDataValid, bus.storeComplete, bus.dataError, bus.busy};
  endfunction

  // Completion monitor: every pulse must match the oldest queued expectation.
  always begin
    logic [4:0] pulses;
    exp_t e;
    @(posedge clock);
    #2;
    pulses = {bus.fetchDataValid, bus.fetchError, bus.loadDataValid, bus.storeComplete, bus.dataError};
    if (pulses != 5'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {27'b0, pulses}, 32'b0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_pulses"}, {27'b0, pulses}, {27'b0, e.pulses});
        if (e.check_data) begin
          check({e.tag, "_data"}, bus.fetchDataValid ? bus.fetchData : bus.loadData, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n;
    int early;
    reset = 1'b1;
    mem_auto = 1'b0;
    rdata_manual = '0;
    bus.fetchReq = 0; bus.fetchAddr = '0; bus.fetchKill = 0;
    bus.dataReadReq = 0; bus.dataWriteReq = 0; bus.dataAddr = '0;
    bus.dataWdata = '0; bus.dataByteEnable = '0;
    bus.memReady = 0; bus.memRespValid = 0;
    #2 reset = 1'b0;
    repeat (2) step();
    check("reset_ctrl", {20'b0, ctrl_vec()}, 32'b0);
    check("reset_memaddr", bus.memAddr, 32'b0);
    reset = 1'b1;
    step();

    // Single load, minimum latency
    bus.dataReadReq = 1; bus.dataAddr = 32'h0000_0104;
    sb.push_back('{"load_104", P_LV, 32'hDEAD_BEEF, 1'b1});
    step();
    bus.dataReadReq = 0; bus.memReady = 1;
    check("load_memreq_c1", bus.memReq, 1);
    check("load_memaddr_c1", bus.memAddr, 32'h104);
    check("load_be_write_c1", {27'b0, bus.memWrite, bus.memByteEnable}, 32'h0F);
    step();
    bus.memReady = 0; bus.memRespValid = 1; rdata_manual = 32'hDEAD_BEEF;
    step();
    bus.memRespValid = 0;
    check("load_valid_c3", {30'b0, bus.loadDataValid, bus.fetchDataValid}, 32'h2);
    check("load_data_c3", bus.loadData, 32'hDEAD_BEEF);
    step();

    // Store with partial byte enables and unaligned address
    bus.dataWriteReq = 1; bus.dataAddr = 32'h0000_0006;
    bus.dataWdata = 32'hABCD_0000; bus.dataByteEnable = 4'b1100;
    sb.push_back('{"store_6", P_SC, 32'h0, 1'b0});
    step();
    check("store_fields", {27'b0, bus.memReq, bus.memWrite, bus.memByteEnable[2:0]}, {27'b0, 2'b11, 3'b100});
    check("store_memaddr", bus.memAddr, 32'h4);
    check("store_wdata", bus.memWdata, 32'hABCD_0000);
    bus.memReady = 1;
    step();
    bus.memReady = 0; bus.memRespValid = 1;
    step();
    bus.memRespValid = 0;
    check("store_complete", bus.storeComplete, 1);
    bus.dataWriteReq = 0;
    step();
    step();
    check("store_single_pulse", {31'b0, bus.storeComplete}, 32'b0);

    // Fetch killed while in WAIT: response consumed, no pulse
    bus.fetchReq = 1; bus.fetchAddr = 32'h40;
    step();
    bus.fetchReq = 0; bus.memReady = 1;
    step();
    bus.memReady = 0; bus.fetchKill = 1;
    step();
    bus.fetchKill = 0; bus.memRespValid = 1; rdata_manual = 32'h1111_2222;
    step();
    bus.memRespValid = 0;
    check("kill_wait_resp", {30'b0, bus.fetchDataValid, bus.busy}, 32'h1);
    step();
    check("kill_back_idle", bus.busy, 0);

    // Normal fetch afterwards, then a fetch killed in its RESP cycle
    bus.memReady = 1; bus.memRespValid = 1; mem_auto = 1;
    bus.fetchReq = 1; bus.fetchAddr = 32'h80;
    sb.push_back('{"fetch_80", P_FV, 32'hC0DE_0080, 1'b1});
    step();
    bus.fetchReq = 0;
    step();
    step();
    check("fetch_80_valid", bus.fetchDataValid, 1);
    step();
    bus.fetchReq = 1; bus.fetchAddr = 32'hC0;
    step();
    bus.fetchReq = 0;
    step();
    step();
    bus.fetchKill = 1;
    #1;
    check("kill_resp_cycle", bus.fetchDataValid, 0);
    step();
    bus.fetchKill = 0;

    // Contention: last owner was fetch, so order is DATA, FETCH, DATA, FETCH
    sb.push_back('{"cont_1_data", P_LV, 32'hC0DE_0300, 1'b1});
    sb.push_back('{"cont_2_fetch", P_FV, 32'hC0DE_0200, 1'b1});
    sb.push_back('{"cont_3_data", P_LV, 32'hC0DE_0300, 1'b1});
    sb.push_back('{"cont_4_fetch", P_FV, 32'hC0DE_0200, 1'b1});
    bus.fetchReq = 1; bus.fetchAddr = 32'h200;
    bus.dataReadReq = 1; bus.dataAddr = 32'h300;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      step();
      if (bus.loadDataValid || bus.fetchDataValid) n++;
    end
    bus.fetchReq = 0; bus.dataReadReq = 0;
    check("contention_count", n, 4);
    step();

    // Watchdog timeout on a load, TIMEOUT_CYCLES = 8
    bus.memRespValid = 0; mem_auto = 0;
    bus.dataReadReq = 1; bus.dataAddr = 32'h500;
    sb.push_back('{"timeout_500", P_LV | P_DE, 32'h0, 1'b0});
    step();
    bus.dataReadReq = 0;
    step();
    bus.memReady = 0;
    early = 0;
    for (int k = 1; k < 8; k++) begin
      step();
      if (bus.loadDataValid || bus.dataError) early++;
    end
    check("timeout_no_early", early, 0);
    step();
    check("timeout_pulses_wait8", {30'b0, bus.loadDataValid, bus.dataError}, 32'h3);
    step();
    check("timeout_idle", bus.busy, 0);

    // Reset in WAIT, then a late response must be ignored
    bus.memReady = 1; bus.dataReadReq = 1; bus.dataAddr = 32'h600;
    step();
    bus.dataReadReq = 0;
    step();
    bus.memReady = 0;
    reset = 1'b0;
    #1;
    check("midreset_ctrl", {20'b0, ctrl_vec()}, 32'b0);
    check("midreset_memaddr", bus.memAddr, 32'b0);
    check("midreset_data", bus.loadData | bus.fetchData | bus.memWdata, 32'b0);
    step();
    step();
    reset = 1'b1;
    bus.memRespValid = 1; rdata_manual = 32'h0000_0077;
    step();
    step();
    step();
    bus.memRespValid = 0;
    check("late_resp_ignored", {30'b0, bus.loadDataValid, bus.busy}, 32'b0);
    repeat (3) step();
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
